hamming_enc_param: RTL and testbench

- Parametrised multicycle Hamming encoder with a valid/ready handshake on input and output.
- Generalises the fixed 4-bit (7,4) encoder to any data width, and adds an optional SECDED overall parity bit and back-to-back streaming.
- Check bits are formed by XOR-accumulating the codeword position index of every '1' data bit, one data bit per cycle.
- Sits between a data source and a channel/memory model; it pairs with the matching parametrised decoder.

---
 rtl/hamming_pkg.sv | 44 ++++
 rtl/hamming_cw_assemble.sv | 34 +++
 rtl/hamming_enc_param.sv | 119 +++++++++++
 tb/tb_hamming_enc_param.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared helpers for the parametrised Hamming encoder/decoder pair:
// code geometry, position mapping and the FSM state type.
package hamming_pkg;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_e;

  // True for 1, 2, 4, 8 ... (the check-bit positions).
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Smallest r with 2^r >= dw + r + 1.
  function automatic int calc_r(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++)
      if (r == 0 && (1 << i) >= dw + i + 1) r = i;
    return r;
  endfunction

  // Codeword position (1-based) of data bit k: the k-th non-power-of-two slot.
  function automatic int data_pos(input int k, input int dw);
    int pos;
    int cnt;
    int n;
    pos = 0;
    cnt = 0;
    n   = dw + calc_r(dw);
    for (int p = 1; p <= n; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Inverse of data_pos for a non-power-of-two position p: subtract the
  // number of check slots at or below p ($clog2(p) when p is not a power of 2).
  function automatic int data_idx(input int p);
    return p - 1 - $clog2(p);
  endfunction

endpackage

// File: rtl/hamming_cw_assemble.sv
// Combinational codeword builder: scatters data bits and check bits into
// their positions and optionally appends the overall (SECDED) parity bit.
module hamming_cw_assemble
  import hamming_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int EXTENDED = 0,
  localparam int R       = calc_r(DATA_W),
  localparam int N       = DATA_W + R,
  localparam int CODE_W  = N + ((EXTENDED != 0) ? 1 : 0)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [R-1:0]      acc_i,
  output logic [CODE_W-1:0] code_o
);

  logic [N-1:0] base;

  // Position p lives at bit p-1; check bit j sits at position 2^j.
  for (genvar p = 1; p <= N; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      assign base[p-1] = acc_i[$clog2(p)];
    end else begin : g_dat
      assign base[p-1] = data_i[data_idx(p)];
    end
  end

  if (EXTENDED != 0) begin : g_ext
    assign code_o = {^base, base};
  end else begin : g_plain
    assign code_o = base;
  end

endmodule

// File: rtl/hamming_enc_param.sv
// Multicycle parametrised Hamming encoder. Check bits are the XOR of the
// codeword positions of every set data bit, accumulated one bit per cycle.
// valid/ready on both sides; OUT can hand off and capture in the same cycle.
module hamming_enc_param
  import hamming_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int EXTENDED = 0,
  localparam int R       = calc_r(DATA_W),
  localparam int N       = DATA_W + R,
  localparam int CODE_W  = N + ((EXTENDED != 0) ? 1 : 0)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [R-1:0]        acc_q, acc_d, acc_next;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic [CODE_W-1:0]   cw;
  logic [R-1:0]        pos_lut [DATA_W];

  // Constant table: codeword position of each data bit.
  for (genvar k = 0; k < DATA_W; k++) begin : g_lut
    assign pos_lut[k] = R'(data_pos(k, DATA_W));
  end

  assign acc_next = acc_q ^ (data_q[idx_q] ? pos_lut[idx_q] : '0);

  hamming_cw_assemble #(
    .DATA_W  (DATA_W),
    .EXTENDED(EXTENDED)
  ) u_asm (
    .data_i(data_q),
    .acc_i (acc_next),
    .code_o(cw)
  );

  assign out_valid = valid_q;
  assign out_code  = code_q;
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: capture, accumulate one data bit per cycle, present, release.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    code_d  = code_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_next;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          code_d  = cw;
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (in_valid) begin
            data_d  = in_data;
            acc_d   = '0;
            idx_d   = '0;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_param.sv
// Directed and streaming checks of hamming_enc_param across several widths.
module tb_hamming_enc_param;

  localparam int NI = 5;
  localparam int DW  [NI] = '{4, 4, 11, 26, 8};
  localparam int EXT [NI] = '{0, 1, 1, 0, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv [NI];
  logic        ordy [NI];
  logic        ir [NI];
  logic        ov [NI];
  logic        bz [NI];
  logic [31:0] din [NI];
  logic [31:0] code [NI];

  logic [6:0]  c0;
  logic [7:0]  c1;
  logic [15:0] c2;
  logic [30:0] c3;
  logic [12:0] c4;

  assign code[0] = {25'd0, c0};
  assign code[1] = {24'd0, c1};
  assign code[2] = {16'd0, c2};
  assign code[3] = {1'b0, c3};
  assign code[4] = {19'd0, c4};

  int n_assert = 0;
  int n_fail   = 0;

  hamming_enc_param #(.DATA_W(4), .EXTENDED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0][3:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_code(c0), .busy(bz[0]));
  hamming_enc_param #(.DATA_W(4), .EXTENDED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1][3:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_code(c1), .busy(bz[1]));
  hamming_enc_param #(.DATA_W(11), .EXTENDED(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[2][10:0]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_code(c2), .busy(bz[2]));
  hamming_enc_param #(.DATA_W(26), .EXTENDED(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(din[3][25:0]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_code(c3), .busy(bz[3]));
  hamming_enc_param #(.DATA_W(8), .EXTENDED(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_data(din[4][7:0]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_code(c4), .busy(bz[4]));

  // Reference: place data, then each check bit = parity of positions with bit j set.
  function automatic logic [31:0] model(input logic [31:0] d, input int dw, input int ext);
    logic [31:0] cw;
    logic        par;
    int          r;
    int          n;
    int          k;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    n  = dw + r;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < r; j++) begin
      par = 1'b0;
      for (int p = 1; p <= n; p++)
        if (((p >> j) & 1) == 1) par ^= cw[p-1];
      cw[(1 << j) - 1] = par;
    end
    if (ext != 0) begin
      par = 1'b0;
      for (int p = 0; p < n; p++) par ^= cw[p];
      cw[n] = par;
    end
    return cw;
  endfunction

  // Drive one word on instance k, return its codeword, latency from accept
  // edge to out_valid, and whether busy stayed high in between.
  task automatic send(input int k, input logic [31:0] d, output logic [31:0] c,
                      output int lat, output bit bz_ok);
    int guard;
    @(negedge clk);
    iv[k]  = 1'b1;
    din[k] = d;
    guard  = 0;
    while (!ir[k] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    iv[k]  = 1'b0;
    din[k] = ~d;
    lat    = 0;
    bz_ok  = 1'b1;
    while (!ov[k] && lat < 100) begin
      if (!bz[k]) bz_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    c = code[k];
    if (!ov[k]) begin
      n_assert++;
      n_fail++;
      $display("FAIL send_timeout inst=%0d: out_valid never rose", k);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < NI; k++) begin
      n_assert++;
      if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid inst=%0d got %b want 0", k, ov[k]); end
      n_assert++;
      if (code[k] !== 32'd0) begin n_fail++; $display("FAIL rst_out_code inst=%0d got %h want 0", k, code[k]); end
      n_assert++;
      if (bz[k] !== 1'b0) begin n_fail++; $display("FAIL rst_busy inst=%0d got %b want 0", k, bz[k]); end
      n_assert++;
      if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready inst=%0d got %b want 1", k, ir[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if (ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_idle got ready=%b busy=%b want 1/0", ir[0], bz[0]);
    end
  endtask

  task automatic test_basic;
    logic [31:0] c;
    int lat;
    bit bok;
    send(0, 32'hB, c, lat, bok);
    n_assert++;
    if (c !== 32'h55) begin n_fail++; $display("FAIL basic_code got %h want 55", c); end
    n_assert++;
    if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", lat); end
    n_assert++;
    if (bok !== 1'b1) begin n_fail++; $display("FAIL basic_busy got low during CALC want high"); end
    @(posedge clk);
    #1;
    n_assert++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release got valid=%b busy=%b want 0/0", ov[0], bz[0]);
    end
  endtask

  task automatic test_extended4;
    logic [31:0] vin [3] = '{32'hF, 32'h0, 32'hB};
    logic [31:0] vexp [3] = '{32'hFF, 32'h00, 32'h55};
    logic [31:0] c;
    int lat;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      send(1, vin[i], c, lat, bok);
      n_assert++;
      if (c !== vexp[i]) begin n_fail++; $display("FAIL ext4_code[%0d] got %h want %h", i, c, vexp[i]); end
    end
    @(posedge clk);
  endtask

  task automatic test_width11;
    logic [31:0] c;
    int lat;
    bit bok;
    send(2, 32'h001, c, lat, bok);
    n_assert++;
    if (c !== 32'h8007) begin n_fail++; $display("FAIL w11_one got %h want 8007", c); end
    n_assert++;
    if (lat !== 11) begin n_fail++; $display("FAIL w11_latency got %0d want 11", lat); end
    send(2, 32'h7FF, c, lat, bok);
    n_assert++;
    if (c !== 32'hFFFF) begin n_fail++; $display("FAIL w11_ones got %h want ffff", c); end
    @(posedge clk);
  endtask

  task automatic test_backpressure;
    logic [31:0] c;
    int lat;
    bit bok;
    ordy[0] = 1'b0;
    send(0, 32'hB, c, lat, bok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv[0]  = 1'b1;
      din[0] = $urandom;
      @(posedge clk);
      #1;
      n_assert++;
      if (ov[0] !== 1'b1 || code[0] !== 32'h55 || ir[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got valid=%b code=%h ready=%b want 1/55/0", i, ov[0], code[0], ir[0]);
      end
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    din[0]  = 32'h6;
    @(posedge clk);
    #1;
    iv[0]  = 1'b0;
    din[0] = 32'hF;
    n_assert++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_handoff got valid=%b busy=%b want 0/1", ov[0], bz[0]);
    end
    lat = 0;
    while (!ov[0] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_assert++;
    if (lat !== 4 || code[0] !== 32'h33) begin
      n_fail++;
      $display("FAIL bp_next got lat=%0d code=%h want 4/33", lat, code[0]);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] c;
    int lat;
    bit bok;
    @(negedge clk);
    iv[0]  = 1'b1;
    din[0] = 32'hB;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_calc got valid=%b busy=%b ready=%b want 0/0/1", ov[0], bz[0], ir[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b0;
    send(0, 32'hB, c, lat, bok);
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || code[0] !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_out got valid=%b busy=%b code=%h want 0/0/0", ov[0], bz[0], code[0]);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    ordy[0] = 1'b1;
    send(0, 32'h6, c, lat, bok);
    n_assert++;
    if (c !== 32'h33 || lat !== 4) begin
      n_fail++;
      $display("FAIL rst_recover got code=%h lat=%0d want 33/4", c, lat);
    end
    @(posedge clk);
  endtask

  task automatic test_stream(input int k, input int nw);
    logic [31:0] exp_q [$];
    logic [31:0] mask;
    int got;
    mask = (32'd1 << DW[k]) - 32'd1;
    got  = 0;
    fork
      begin
        for (int i = 0; i < nw; i++) begin
          logic [31:0] d;
          int guard;
          d = $urandom & mask;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(negedge clk);
          iv[k]  = 1'b1;
          din[k] = d;
          guard  = 0;
          while (!ir[k] && guard < 500) begin
            @(negedge clk);
            guard++;
          end
          if (!ir[k]) begin
            n_assert++;
            n_fail++;
            $display("FAIL stream_accept_timeout inst=%0d word=%0d", k, i);
            break;
          end
          exp_q.push_back(model(d, DW[k], EXT[k]));
          @(posedge clk);
          #1;
          iv[k] = 1'b0;
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < nw && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (ov[k] && ordy[k]) begin
            n_assert++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL stream_extra inst=%0d got %h want nothing", k, code[k]);
            end else begin
              logic [31:0] e;
              e = exp_q.pop_front();
              if (code[k] !== e) begin
                n_fail++;
                $display("FAIL stream_code inst=%0d word=%0d got %h want %h", k, got, code[k], e);
              end
            end
            got++;
          end
          @(posedge clk);
          #2;
          ordy[k] = ($urandom_range(0, 3) != 0);
        end
        ordy[k] = 1'b1;
      end
    join
    n_assert++;
    if (got !== nw || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stream_count inst=%0d got %0d words (%0d pending) want %0d", k, got, exp_q.size(), nw);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      din[k]  = '0;
    end
    test_reset;
    test_basic;
    test_extended4;
    test_width11;
    test_backpressure;
    test_reset_mid;
    test_stream(0, 250);
    test_stream(4, 250);
    test_stream(2, 250);
    test_stream(3, 250);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
